// File: rtl/easy_axis_pkg.sv
// Shared helpers for the easy_axis stream blocks: width arithmetic and
// lane-index typing used by the width converters and register slices.
package easy_axis_pkg;

  function automatic int clog2_min1(input int x);
    return ($clog2(x) < 1) ? 1 : $clog2(x);
  endfunction

  // Port width for optional sidebands: a zero-width field still needs one bit.
  function automatic int width_val(input int x);
    return (x <= 0) ? 1 : x;
  endfunction

  localparam int DEF_S_DWIDTH = 64;
  localparam int DEF_M_DWIDTH = 16;
  localparam int DEF_RATIO    = DEF_S_DWIDTH / DEF_M_DWIDTH;

  typedef logic [clog2_min1(DEF_RATIO)-1:0] lane_idx_t;

endpackage

// File: rtl/easy_axis_reg_slice.sv
// Two-entry skid buffer: fully registered valid/data toward the sink and a
// registered ready toward the source, full throughput under streaming.
module easy_axis_reg_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [WIDTH-1:0] main_data;
  logic             main_valid;
  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;

  // The skid entry only fills when the main entry is stalled, so ready is
  // simply "skid slot free" and never depends on m_ready combinationally.
  assign s_ready = !skid_valid;
  assign m_data  = main_data;
  assign m_valid = main_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_data  <= '0;
      main_valid <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (m_ready) begin
        main_data  <= skid_data;
        skid_valid <= 1'b0;
      end
    end else if (s_valid) begin
      if (!main_valid || m_ready) begin
        main_data  <= s_data;
        main_valid <= 1'b1;
      end else begin
        skid_data  <= s_data;
        skid_valid <= 1'b1;
      end
    end else if (m_ready) begin
      main_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/easy_axis_downsizer.sv
// AXI-Stream width down-converter: splits each wide beat into narrow lanes,
// least-significant first, skipping trailing lanes whose tkeep is all zero.
module easy_axis_downsizer
  import easy_axis_pkg::*;
#(
  parameter int S_DWIDTH   = 64,
  parameter int M_DWIDTH   = 16,
  parameter int HAS_KEEP   = 0,
  parameter int HAS_LAST   = 0,
  parameter int USER_WIDTH = 0,
  parameter int OUTPUT_REG = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [S_DWIDTH-1:0]              s_axis_tdata,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic [S_DWIDTH/8-1:0]            s_axis_tkeep,
  input  logic                             s_axis_tlast,
  input  logic [width_val(USER_WIDTH)-1:0] s_axis_tuser,
  output logic [M_DWIDTH-1:0]              m_axis_tdata,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [M_DWIDTH/8-1:0]            m_axis_tkeep,
  output logic                             m_axis_tlast,
  output logic [width_val(USER_WIDTH)-1:0] m_axis_tuser
);

  localparam int RATIO = S_DWIDTH / M_DWIDTH;
  localparam int IDX_W = clog2_min1(RATIO);
  localparam int KW_S  = S_DWIDTH / 8;
  localparam int KW_M  = M_DWIDTH / 8;
  localparam int UW    = width_val(USER_WIDTH);

  typedef logic [IDX_W-1:0] idx_t;

  if ((S_DWIDTH % 8) != 0 || (M_DWIDTH % 8) != 0) begin : g_bad_bytes
    $error("easy_axis_downsizer: data widths must be multiples of 8");
  end
  if ((S_DWIDTH % M_DWIDTH) != 0 || RATIO < 2 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
    $error("easy_axis_downsizer: S_DWIDTH/M_DWIDTH must be a power of 2 >= 2");
  end

  logic [S_DWIDTH-1:0] hold_data;
  logic [KW_S-1:0]     hold_keep;
  logic                hold_last;
  logic [UW-1:0]       hold_user;
  logic                hold_valid;
  idx_t                idx;

  logic [KW_S-1:0]     keep_in;
  logic                last_in;
  logic [UW-1:0]       user_in;
  logic [RATIO-1:0]    lane_final;
  logic                cur_final;
  logic                int_ready;
  logic                load;

  // Absent tkeep is folded in at load time so every lane reads as full.
  assign keep_in = (HAS_KEEP != 0) ? s_axis_tkeep : '1;
  assign last_in = (HAS_LAST != 0) && s_axis_tlast;
  assign user_in = (USER_WIDTH > 0) ? s_axis_tuser : '0;

  always_comb begin
    lane_final = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (k == RATIO - 1)
        lane_final[k] = 1'b1;
      else if (HAS_KEEP != 0)
        lane_final[k] = ((hold_keep >> ((k + 1) * KW_M)) == '0);
    end
  end

  assign cur_final     = lane_final[idx];
  assign s_axis_tready = rst_n && (!hold_valid || (cur_final && int_ready));
  assign load          = s_axis_tvalid && s_axis_tready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_data  <= '0;
      hold_keep  <= '0;
      hold_last  <= 1'b0;
      hold_user  <= '0;
      hold_valid <= 1'b0;
      idx        <= '0;
    end else if (load) begin
      hold_data  <= s_axis_tdata;
      hold_keep  <= keep_in;
      hold_last  <= last_in;
      hold_user  <= user_in;
      hold_valid <= 1'b1;
      idx        <= '0;
    end else if (hold_valid && int_ready) begin
      if (cur_final) begin
        hold_valid <= 1'b0;
        idx        <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  logic [M_DWIDTH-1:0] lane_data;
  logic [KW_M-1:0]     lane_keep;
  logic                lane_last;

  assign lane_data = hold_data[int'(idx) * M_DWIDTH +: M_DWIDTH];
  assign lane_keep = hold_keep[int'(idx) * KW_M +: KW_M];
  assign lane_last = hold_last && cur_final;

  if (OUTPUT_REG != 0) begin : g_out_reg
    localparam int PW = M_DWIDTH + KW_M + 1 + UW;
    logic [PW-1:0] slice_out;

    easy_axis_reg_slice #(.WIDTH(PW)) u_out_slice (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_data  ({lane_data, lane_keep, lane_last, hold_user}),
      .s_valid (hold_valid),
      .s_ready (int_ready),
      .m_data  (slice_out),
      .m_valid (m_axis_tvalid),
      .m_ready (m_axis_tready)
    );

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} = slice_out;
  end else begin : g_out_direct
    assign int_ready     = m_axis_tready;
    assign m_axis_tvalid = hold_valid;
    assign m_axis_tdata  = lane_data;
    assign m_axis_tkeep  = lane_keep;
    assign m_axis_tlast  = lane_last;
    assign m_axis_tuser  = hold_user;
  end

endmodule

// File: tb/tb_easy_axis_downsizer.sv
// Directed and randomized checks of the 64->16 downsizer with keep, last and
// a 4-bit user sideband.
module tb_easy_axis_downsizer;

  localparam int W = 23;  // {data16, keep2, last, user4}

  logic        clk;
  logic        rst_n;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tlast;
  logic [3:0]  s_axis_tuser;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [1:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic [3:0]  m_axis_tuser;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  logic         drv_done;
  int           drv_timeouts;

  easy_axis_downsizer #(
    .S_DWIDTH  (64),
    .M_DWIDTH  (16),
    .HAS_KEEP  (1),
    .HAS_LAST  (1),
    .USER_WIDTH(4),
    .OUTPUT_REG(0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tuser (s_axis_tuser),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- driver tasks ----------------
  // All activity sits at posedge+1 (drive) and posedge+2 (sample).
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [63:0] d, input logic [7:0] k,
                            input logic l, input logic [3:0] u);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
  endtask

  // Reference model: lanes up to the highest lane with any keep bit set.
  task automatic push_expected(input logic [63:0] d, input logic [7:0] k,
                               input logic l, input logic [3:0] u);
    int top;
    top = 0;
    for (int i = 0; i < 4; i++)
      if (k[2*i +: 2] != 2'b00) top = i;
    for (int i = 0; i <= top; i++)
      exp_q.push_back({d[16*i +: 16], k[2*i +: 2], l && (i == top), u});
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n         = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = '0;
    m_axis_tready = 1'b1;
    tick;
    tick;
    #1;
    total++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} !== 24'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=%h",
               {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, 24'h0);
    end
    total++;
    if (s_axis_tready !== 1'b0) begin
      bad++;
      $display("FAIL reset_s_ready_low got=%b exp=0", s_axis_tready);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (s_axis_tready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_s_ready got=%b exp=1", s_axis_tready);
    end
    tick;
  endtask

  task automatic test_full_beat;
    logic [15:0] ed[4];
    ed = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    drive_beat(64'h4444_3333_2222_1111, 8'hFF, 1'b1, 4'hA);
    m_axis_tready = 1'b1;
    #1;
    total++;
    if (s_axis_tready !== 1'b1) begin
      bad++;
      $display("FAIL full_accept_ready got=%b exp=1", s_axis_tready);
    end
    tick;
    s_axis_tvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++;
      if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} !==
          {1'b1, ed[k], 2'b11, (k == 3), 4'hA}) begin
        bad++;
        $display("FAIL full_lane%0d got=%h exp=%h", k,
                 {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser},
                 {1'b1, ed[k], 2'b11, (k == 3), 4'hA});
      end
      tick;
    end
    #1;
    total++;
    if (m_axis_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL full_drained_valid got=%b exp=0", m_axis_tvalid);
    end
    tick;
  endtask

  task automatic test_partial_keep;
    drive_beat(64'hDEAD_BEEF_BBBB_AAAA, 8'h0F, 1'b1, 4'h3);
    tick;
    s_axis_tvalid = 1'b0;
    #1;
    total++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} !==
        {1'b1, 16'hAAAA, 2'b11, 1'b0, 4'h3}) begin
      bad++;
      $display("FAIL partial_lane0 got=%h exp=%h",
               {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser},
               {1'b1, 16'hAAAA, 2'b11, 1'b0, 4'h3});
    end
    total++;
    if (s_axis_tready !== 1'b0) begin
      bad++;
      $display("FAIL partial_lane0_s_ready got=%b exp=0", s_axis_tready);
    end
    tick;
    #1;
    total++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} !==
        {1'b1, 16'hBBBB, 2'b11, 1'b1, 4'h3}) begin
      bad++;
      $display("FAIL partial_lane1 got=%h exp=%h",
               {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser},
               {1'b1, 16'hBBBB, 2'b11, 1'b1, 4'h3});
    end
    total++;
    if (s_axis_tready !== 1'b1) begin
      bad++;
      $display("FAIL partial_final_s_ready got=%b exp=1", s_axis_tready);
    end
    tick;
    #1;
    total++;
    if (m_axis_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL partial_drained_valid got=%b exp=0", m_axis_tvalid);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [63:0] bb[3];
    logic [23:0] exp_v;
    int nb, b, l;
    bb = '{64'h1003_1002_1001_1000, 64'h2003_2002_2001_2000, 64'h3003_3002_3001_3000};
    nb = 0;
    m_axis_tready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (nb < 3) drive_beat(bb[nb], 8'hFF, (nb == 2), 4'(nb + 4));
      else s_axis_tvalid = 1'b0;
      #1;
      if (c >= 1 && c <= 12) begin
        b = (c - 1) / 4;
        l = (c - 1) % 4;
        exp_v = {1'b1, bb[b][16*l +: 16], 2'b11, (b == 2 && l == 3), 4'(b + 4)};
      end else begin
        exp_v = 24'h0;
      end
      total++;
      if (m_axis_tvalid !== exp_v[23] ||
          (exp_v[23] && {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} !== exp_v)) begin
        bad++;
        $display("FAIL b2b_cycle%0d got=%h exp=%h", c,
                 {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, exp_v);
      end
      if (c <= 8) begin
        total++;
        if (s_axis_tready !== ((c % 4) == 0)) begin
          bad++;
          $display("FAIL b2b_s_ready_cycle%0d got=%b exp=%b", c, s_axis_tready, ((c % 4) == 0));
        end
      end
      if (s_axis_tvalid && s_axis_tready) nb++;
      tick;
    end
  endtask

  task automatic test_null_keep;
    logic [15:0] ed[4];
    logic [1:0]  ek[4];
    drive_beat(64'h1234_5678_9ABC_DEF0, 8'h00, 1'b1, 4'h1);
    tick;
    s_axis_tvalid = 1'b0;
    #1;
    total++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} !==
        {1'b1, 16'hDEF0, 2'b00, 1'b1, 4'h1}) begin
      bad++;
      $display("FAIL null_keep00_lane0 got=%h exp=%h",
               {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser},
               {1'b1, 16'hDEF0, 2'b00, 1'b1, 4'h1});
    end
    tick;
    #1;
    total++;
    if (m_axis_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL null_keep00_single got=%b exp=0", m_axis_tvalid);
    end
    tick;

    ed = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    ek = '{2'b11, 2'b00, 2'b11, 2'b11};
    drive_beat(64'h4444_3333_2222_1111, 8'hF3, 1'b1, 4'h2);
    tick;
    s_axis_tvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++;
      if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} !==
          {1'b1, ed[k], ek[k], (k == 3), 4'h2}) begin
        bad++;
        $display("FAIL keepF3_lane%0d got=%h exp=%h", k,
                 {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser},
                 {1'b1, ed[k], ek[k], (k == 3), 4'h2});
      end
      tick;
    end
    #1;
    total++;
    if (m_axis_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL keepF3_drained got=%b exp=0", m_axis_tvalid);
    end
    tick;
  endtask

  task automatic test_reset_mid_beat;
    logic [15:0] ed[4];
    m_axis_tready = 1'b1;
    drive_beat(64'hDDDD_CCCC_BBBB_AAAA, 8'hFF, 1'b1, 4'h6);
    tick;
    s_axis_tvalid = 1'b0;
    #1;
    total++;
    if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 16'hAAAA}) begin
      bad++;
      $display("FAIL rmid_lane0 got=%h exp=%h", {m_axis_tvalid, m_axis_tdata}, {1'b1, 16'hAAAA});
    end
    tick;
    #1;
    total++;
    if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 16'hBBBB}) begin
      bad++;
      $display("FAIL rmid_lane1 got=%h exp=%h", {m_axis_tvalid, m_axis_tdata}, {1'b1, 16'hBBBB});
    end
    tick;
    rst_n = 1'b0;
    tick;
    #1;
    total++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} !== 24'h0) begin
      bad++;
      $display("FAIL rmid_after_reset got=%h exp=%h",
               {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, 24'h0);
    end
    total++;
    if (s_axis_tready !== 1'b0) begin
      bad++;
      $display("FAIL rmid_s_ready_in_reset got=%b exp=0", s_axis_tready);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (s_axis_tready !== 1'b1) begin
      bad++;
      $display("FAIL rmid_s_ready_release got=%b exp=1", s_axis_tready);
    end
    for (int c = 0; c < 2; c++) begin
      tick;
      #1;
      total++;
      if (m_axis_tvalid !== 1'b0) begin
        bad++;
        $display("FAIL rmid_residual_cycle%0d got=%b exp=0", c, m_axis_tvalid);
      end
    end
    tick;
    ed = '{16'h5555, 16'h6666, 16'h7777, 16'h8888};
    drive_beat(64'h8888_7777_6666_5555, 8'hFF, 1'b1, 4'h7);
    tick;
    s_axis_tvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++;
      if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} !==
          {1'b1, ed[k], 2'b11, (k == 3), 4'h7}) begin
        bad++;
        $display("FAIL rmid_next_lane%0d got=%h exp=%h", k,
                 {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser},
                 {1'b1, ed[k], 2'b11, (k == 3), 4'h7});
      end
      tick;
    end
  endtask

  task automatic test_random;
    drv_done     = 1'b0;
    drv_timeouts = 0;
    exp_q.delete();
    fork
      begin : driver
        logic [63:0] d;
        logic [7:0]  k;
        logic [3:0]  u;
        int nbeats, guard;
        for (int p = 0; p < 1000; p++) begin
          nbeats = $urandom_range(1, 3);
          for (int b = 0; b < nbeats; b++) begin
            if ($urandom_range(0, 3) == 0) begin
              s_axis_tvalid = 1'b0;
              tick;
            end
            d = {$urandom, $urandom};
            k = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom_range(0, 255));
            u = 4'($urandom_range(0, 15));
            drive_beat(d, k, (b == nbeats - 1), u);
            #1;
            guard = 0;
            while (!s_axis_tready && guard < 200) begin
              @(posedge clk);
              #2;
              guard++;
            end
            if (guard >= 200) drv_timeouts++;
            push_expected(d, k, (b == nbeats - 1), u);
            tick;
          end
        end
        s_axis_tvalid = 1'b0;
        drv_done = 1'b1;
      end
      begin : monitor
        logic [23:0] cur, prev;
        logic [W-1:0] e;
        logic stall;
        int cyc;
        stall = 1'b0;
        prev  = '0;
        cyc   = 0;
        while (cyc < 80000 && !(drv_done && exp_q.size() == 0)) begin
          tick;
          cyc++;
          cur = {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
          if (stall) begin
            total++;
            if (cur !== prev) begin
              bad++;
              $display("FAIL rand_stall_stable got=%h exp=%h", cur, prev);
            end
          end
          m_axis_tready = 1'($urandom_range(0, 1));
          stall = m_axis_tvalid && !m_axis_tready;
          prev  = cur;
          if (m_axis_tvalid && m_axis_tready) begin
            total++;
            if (exp_q.size() == 0) begin
              bad++;
              $display("FAIL rand_unexpected_beat got=%h exp=none", cur[W-1:0]);
            end else begin
              e = exp_q.pop_front();
              if (cur[W-1:0] !== e) begin
                bad++;
                $display("FAIL rand_beat got=%h exp=%h", cur[W-1:0], e);
              end
            end
          end
        end
        m_axis_tready = 1'b1;
      end
    join
    total++;
    if (exp_q.size() != 0 || drv_timeouts != 0) begin
      bad++;
      $display("FAIL rand_completion got=left%0d/timeouts%0d exp=0/0", exp_q.size(), drv_timeouts);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    #1;
    test_reset;
    test_full_beat;
    test_partial_keep;
    test_back_to_back;
    test_null_keep;
    test_reset_mid_beat;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
